// File: rtl/rom_access_scheduler.sv
// rom_access_scheduler: round-robin arbiter sharing one wait-stated ROM.
// Optional macro ROM_SCHED_PRIO0_EN gives port 0 absolute priority in IDLE.
module rom_access_scheduler #(
    parameter int PORTS       = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                      medClk,
    input  logic                      rstN,
    input  logic [PORTS-1:0]          reqVec,
    input  logic [PORTS*ADDR_W-1:0]   addrIn,
    output logic [PORTS-1:0]          gnt,
    output logic [DATA_W-1:0]         dataOut,
    output logic [PORTS-1:0]          dataValid,
    output logic [ADDR_W-1:0]         romAddr,
    output logic                      romRe,
    input  logic [DATA_W-1:0]         romData
);

    localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int WW = $clog2(WAIT_CYCLES + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [OW:0]   PORTS_X   = (OW + 1)'(PORTS);
    localparam logic [OW-1:0] LAST_PORT = OW'(PORTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [OW-1:0]       owner;
    logic [OW-1:0]       owner_nx;
    logic [OW-1:0]       rr_ptr;
    logic [OW-1:0]       rr_ptr_nx;
    logic [WW-1:0]       wait_cnt;
    logic [WW-1:0]       wait_cnt_nx;
    logic [HW-1:0]       hold_cnt;
    logic [HW-1:0]       hold_cnt_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_nx;

    logic [ADDR_W-1:0]   port_addr [PORTS];
    logic [PORTS-1:0]    rot;
    logic [OW:0]         sum;
    logic [OW-1:0]       pick;
    logic                pick_any;
    logic [OW-1:0]       owner_inc;
    logic                keep_ptr;
    logic [PORTS-1:0]    owner_hot;

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign port_addr[i] = addrIn[i*ADDR_W +: ADDR_W];
    end

    // Pick the first requester at or after rr_ptr, wrapping around
    always_comb begin
        rot      = PORTS'({reqVec, reqVec} >> rr_ptr);
        sum      = '0;
        pick     = rr_ptr;
        pick_any = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (!pick_any && rot[k]) begin
                pick_any = 1'b1;
                sum      = {1'b0, rr_ptr} + (OW + 1)'(k);
                if (sum >= PORTS_X) begin
                    sum = sum - PORTS_X;
                end
                pick = sum[OW-1:0];
            end
        end
`ifdef ROM_SCHED_PRIO0_EN
        if (reqVec[0]) begin
            pick     = '0;
            pick_any = 1'b1;
        end
`endif
    end

    // Pointer successor and whether a release should leave it untouched
    always_comb begin
        owner_inc = (owner == LAST_PORT) ? '0 : owner + OW'(1);
`ifdef ROM_SCHED_PRIO0_EN
        keep_ptr  = (owner == '0);
`else
        keep_ptr  = 1'b0;
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge medClk) begin
        if (!rstN) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            wait_cnt <= '0;
            hold_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            wait_cnt <= wait_cnt_nx;
            hold_cnt <= hold_cnt_nx;
            addr_q   <= addr_nx;
            data_q   <= data_nx;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        wait_cnt_nx = wait_cnt;
        hold_cnt_nx = hold_cnt;
        addr_nx     = addr_q;
        data_nx     = data_q;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_nx    = pick;
                    addr_nx     = port_addr[pick];
                    wait_cnt_nx = '0;
                    hold_cnt_nx = '0;
                    state_nx    = ACCESS;
                end
            end
            ACCESS: begin
                wait_cnt_nx = wait_cnt + WW'(1);
                if (wait_cnt == WAIT_LAST) begin
                    data_nx  = romData;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (reqVec[owner] && (hold_cnt < HOLD_LAST)) begin
                    hold_cnt_nx = hold_cnt + HW'(1);
                    addr_nx     = port_addr[owner];
                    wait_cnt_nx = '0;
                    state_nx    = ACCESS;
                end else begin
                    if (!keep_ptr) begin
                        rr_ptr_nx = owner_inc;
                    end
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        owner_hot = PORTS'(1) << owner;
        romRe     = (state != IDLE);
        gnt       = romRe ? owner_hot : '0;
        romAddr   = romRe ? addr_q : '0;
        dataValid = (state == DATA) ? owner_hot : '0;
        dataOut   = data_q;
    end

endmodule

// File: tb/tb_rom_access_scheduler.sv
// tb_rom_access_scheduler: randomized scoreboard bench for the ROM scheduler.
// Reference model tracks grants as access timelines, not as the RTL FSM.
module tb_rom_access_scheduler;

    localparam int PORTS = 4;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int W     = 2;
    localparam int MAXH  = 4;

    logic                  medClk = 1'b0;
    logic                  rstN   = 1'b0;
    logic [PORTS-1:0]      reqVec = '0;
    logic [PORTS*AW-1:0]   addrIn = '0;
    logic [PORTS-1:0]      gnt;
    logic [DW-1:0]         dataOut;
    logic [PORTS-1:0]      dataValid;
    logic [AW-1:0]         romAddr;
    logic                  romRe;
    logic [DW-1:0]         romData;

    always #5 medClk = ~medClk;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign romData = rom_byte(romAddr);

    rom_access_scheduler #(
        .PORTS(PORTS), .ADDR_W(AW), .DATA_W(DW),
        .WAIT_CYCLES(W), .MAX_HOLD(MAXH)
    ) dut (
        .medClk(medClk), .rstN(rstN), .reqVec(reqVec), .addrIn(addrIn),
        .gnt(gnt), .dataOut(dataOut), .dataValid(dataValid),
        .romAddr(romAddr), .romRe(romRe), .romData(romData)
    );

    typedef struct {
        int         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   nchecks = 0;
    int   nerrors = 0;
    int   cyc     = 0;

    // reference model: current owner (-1 = none), edges into this access,
    // accesses done in this grant, preferred next port
    int          m_owner = -1;
    int          m_phase = 0;
    int          m_count = 0;
    int          m_rr    = 0;
    logic [15:0] m_addr  = '0;
    logic [7:0]  m_data  = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] port_addr(input int p);
        return addrIn[p*AW +: AW];
    endfunction

    task automatic start_access();
        exp_t e;
        m_addr  = port_addr(m_owner);
        m_phase = 0;
        e.port  = m_owner;
        e.data  = rom_byte(m_addr);
        e.cyc   = cyc + W;
        sbq.push_back(e);
    endtask

    task automatic model_step();
        int p;
        bit found;
        bit keep;
        if (!rstN) begin
            m_owner = -1; m_phase = 0; m_count = 0;
            m_rr = 0; m_data = '0; m_addr = '0;
            sbq.delete();
            return;
        end
        if (m_owner < 0) begin
            found = 0;
            p = 0;
`ifdef ROM_SCHED_PRIO0_EN
            if (reqVec[0]) found = 1;
`endif
            for (int k = 0; k < PORTS && !found; k++) begin
                p = (m_rr + k) % PORTS;
                if (reqVec[p]) found = 1;
            end
            if (found) begin
                m_owner = p;
                m_count = 1;
                start_access();
            end
        end else if (m_phase < W) begin
            m_phase++;
            if (m_phase == W) m_data = rom_byte(m_addr);
        end else if (reqVec[m_owner] && m_count < MAXH) begin
            m_count++;
            start_access();
        end else begin
            keep = 0;
`ifdef ROM_SCHED_PRIO0_EN
            keep = (m_owner == 0);
`endif
            if (!keep) m_rr = (m_owner + 1) % PORTS;
            m_owner = -1;
            m_phase = 0;
        end
    endtask

    task automatic check_cycle();
        logic [PORTS-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("romRe", 32'(romRe), 32'(m_owner >= 0));
        chk("romAddr", 32'(romAddr), (m_owner >= 0) ? 32'(m_addr) : 32'd0);
        chk("dataOut", 32'(dataOut), 32'(m_data));
    endtask

    task automatic tick();
        @(posedge medClk);
        cyc++;
        model_step();
        #1;
        check_cycle();
        @(negedge medClk);
    endtask

    // scoreboard monitor: every dataValid pulse must match the queue head
    always @(negedge medClk) begin
        exp_t e;
        logic [PORTS-1:0] oh;
        if (dataValid != '0) begin
            if (sbq.size() == 0) begin
                chk("dv_unexpected", 32'(dataValid), 32'd0);
            end else begin
                e = sbq.pop_front();
                oh = '0;
                oh[e.port] = 1'b1;
                chk("dv_port", 32'(dataValid), 32'(oh));
                chk("dv_data", 32'(dataOut), 32'(e.data));
                chk("dv_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            chk("dv_missing", 32'(dataValid), 32'(oh));
        end
    end

    task automatic rand_addrs();
        for (int p = 0; p < PORTS; p++) begin
            addrIn[p*AW +: AW] = 16'($urandom);
        end
    endtask

    initial begin
        // reset held with every port requesting
        rstN = 1'b0;
        reqVec = '1;
        rand_addrs();
        tick();
        tick();
        rstN = 1'b1;
        reqVec = '0;
        tick();

        // single access on port 0
        reqVec = 4'b0001;
        addrIn[15:0] = 16'h1234;
        tick();
        reqVec = '0;
        repeat (6) tick();

        // all ports requesting continuously
        reqVec = '1;
        repeat (70) begin
            rand_addrs();
            tick();
        end
        reqVec = '0;
        repeat (6) tick();

        // burst cap on port 2 with advancing addresses
        for (int i = 0; i < 24; i++) begin
            reqVec = 4'b0100;
            addrIn[2*AW +: AW] = 16'h0100 + 16'(i / (W + 1));
            tick();
        end
        reqVec = '0;
        repeat (6) tick();

        // port 1 drops its request during the access
        reqVec = 4'b0010;
        addrIn[1*AW +: AW] = 16'h0BEE;
        tick();
        tick();
        reqVec = '0;
        repeat (5) tick();
        reqVec = 4'b0110;
        repeat (4) tick();
        reqVec = '0;
        repeat (8) tick();

        // reset in the middle of a burst
        reqVec = '1;
        repeat (5) tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        reqVec = 4'b1010;
        repeat (10) tick();
        reqVec = '0;
        repeat (6) tick();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) reqVec = 4'($urandom);
            if ($urandom_range(0, 1) == 0) rand_addrs();
            rstN = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstN = 1'b1;
        reqVec = '0;
        repeat (20) tick();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
